// File: rtl/o_serializer.sv
// Parallel-to-serial output stage: one-word holding register feeding a shift
// register, with registered Q/OE/WORD_START suitable for driving an I/O buffer.
module o_serializer #(
  parameter int WIDTH      = 8,
  parameter     BIT_ORDER  = "LSB_FIRST",
  parameter int IDLE_VALUE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             Q,
  output logic             OE,
  output logic             WORD_START
);

  if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
    $fatal(1, "%m: WIDTH=%0d is illegal; legal values are 3..10", WIDTH);
  end
  if (BIT_ORDER != "LSB_FIRST" && BIT_ORDER != "MSB_FIRST") begin : g_bad_order
    $fatal(1, "%m: BIT_ORDER=\"%s\" is illegal; legal values are \"LSB_FIRST\", \"MSB_FIRST\"", BIT_ORDER);
  end
  if (IDLE_VALUE != 0 && IDLE_VALUE != 1) begin : g_bad_idle
    $fatal(1, "%m: IDLE_VALUE=%0d is illegal; legal values are 0, 1", IDLE_VALUE);
  end

  localparam bit   MSB_FIRST = (BIT_ORDER == "MSB_FIRST");
  localparam int   CNT_W     = $clog2(WIDTH);
  localparam logic IDLE_BIT  = (IDLE_VALUE != 0);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] hold;
  logic             hold_v;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last;
  logic             load;
  logic             accept;
  logic             out_bit;

  assign D_READY = !hold_v && !RST;
  assign accept  = D_VALID && !hold_v;
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign load    = hold_v && ((state == IDLE) || last);

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    if (load) begin
      sr_n    = hold;
      cnt_n   = '0;
      state_n = SHIFT;
    end else if (state == SHIFT) begin
      if (!last) begin
        sr_n  = MSB_FIRST ? (sr << 1) : (sr >> 1);
        cnt_n = cnt + CNT_W'(1);
      end else begin
        state_n = IDLE;
      end
    end
  end

  // Outputs are registered from next-state values so the first bit is on Q
  // right after the load edge.
  assign out_bit = MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      hold_v     <= 1'b0;
      sr         <= '0;
      Q          <= IDLE_BIT;
      OE         <= 1'b0;
      WORD_START <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      if (accept) hold <= D;
      hold_v     <= accept || (hold_v && !load);
      Q          <= (state_n == SHIFT) ? out_bit : IDLE_BIT;
      OE         <= (state_n == SHIFT);
      WORD_START <= load;
    end
  end

endmodule

// File: tb/tb_o_serializer.sv
// Bench for o_serializer: two 4-bit instances (LSB-first idle-high, MSB-first
// idle-low) checked every cycle against a queue-based transaction model.
module tb_o_serializer;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] D   = '0;
  logic         D_VALID = 1'b0;
  logic         rdy_l, q_l, oe_l, ws_l;
  logic         rdy_m, q_m, oe_m, ws_m;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [W-1:0] m_hold;
  logic         m_hold_v = 1'b0;
  logic         m_ws     = 1'b0;
  logic         bq_l[$];
  logic         bq_m[$];

  always #5 CLK = ~CLK;

  o_serializer #(.WIDTH(W), .BIT_ORDER("LSB_FIRST"), .IDLE_VALUE(1)) u_lsb (
    .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_READY(rdy_l),
    .Q(q_l), .OE(oe_l), .WORD_START(ws_l)
  );

  o_serializer #(.WIDTH(W), .BIT_ORDER("MSB_FIRST"), .IDLE_VALUE(0)) u_msb (
    .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_READY(rdy_m),
    .Q(q_m), .OE(oe_m), .WORD_START(ws_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check D_READY, advance model and DUT, check outputs.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d);
    logic exp_rdy;
    RST = rst; D_VALID = v; D = d;
    #1;
    exp_rdy = !m_hold_v && !rst;
    check("d_ready_lsb", 32'(rdy_l), 32'(exp_rdy));
    check("d_ready_msb", 32'(rdy_m), 32'(exp_rdy));
    @(posedge CLK);
    m_ws = 1'b0;
    if (rst) begin
      bq_l.delete();
      bq_m.delete();
      m_hold_v = 1'b0;
    end else begin
      if (bq_l.size() > 0) begin
        void'(bq_l.pop_front());
        void'(bq_m.pop_front());
      end
      if (bq_l.size() == 0 && m_hold_v) begin
        for (int i = 0; i < W; i++) begin
          bq_l.push_back(m_hold[i]);
          bq_m.push_back(m_hold[W-1-i]);
        end
        m_hold_v = 1'b0;
        m_ws     = 1'b1;
      end
      if (v && exp_rdy) begin
        m_hold   = d;
        m_hold_v = 1'b1;
      end
    end
    #1;
    check("q_lsb",  32'(q_l),  32'((bq_l.size() > 0) ? bq_l[0] : 1'b1));
    check("q_msb",  32'(q_m),  32'((bq_m.size() > 0) ? bq_m[0] : 1'b0));
    check("oe_lsb", 32'(oe_l), 32'(bq_l.size() > 0));
    check("oe_msb", 32'(oe_m), 32'(bq_m.size() > 0));
    check("ws_lsb", 32'(ws_l), 32'(m_ws));
    check("ws_msb", 32'(ws_m), 32'(m_ws));
  endtask

  initial begin
    logic [7:0] seq_l;
    logic [3:0] seq_m;
    int         oe_run;

    // reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF);
    check("rst_q_lsb", 32'(q_l), 32'd1);
    check("rst_oe_lsb", 32'(oe_l), 32'd0);

    // single word 1011: LSB gives 1,1,0,1 and MSB gives 1,0,1,1
    step(1'b0, 1'b1, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0);
      if (i < 4) begin
        seq_l[i] = q_l;
        seq_m[i] = q_m;
      end
      if (i == 0) check("single_ws_first", 32'(ws_l), 32'd1);
      if (i == 1) check("single_ws_second", 32'(ws_l), 32'd0);
    end
    check("single_seq_lsb", 32'(seq_l[3:0]), 32'h0000000B);
    check("single_seq_msb", 32'(seq_m), 32'h0000000D);
    check("single_idle_oe", 32'(oe_l), 32'd0);

    // back-to-back A then 5 with D_VALID held
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b1, 4'h5);
    seq_l[0] = q_l;
    oe_run = int'(oe_l);
    step(1'b0, 1'b1, 4'h5);
    seq_l[1] = q_l;
    oe_run += int'(oe_l);
    for (int i = 2; i < 9; i++) begin
      step(1'b0, 1'b0, '0);
      if (i < 8) begin
        seq_l[i] = q_l;
        oe_run  += int'(oe_l);
      end else begin
        check("b2b_gap_after", 32'(oe_l), 32'd0);
      end
    end
    check("b2b_seq_lsb", 32'(seq_l), 32'h0000005A);
    check("b2b_oe_run", 32'(oe_run), 32'd8);

    // reset mid-word of F, then a clean 0 word
    step(1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 4'h3);
    check("rstmid_q", 32'(q_l), 32'd1);
    check("rstmid_oe", 32'(oe_l), 32'd0);
    step(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);

    // backpressure: D_VALID held with changing data
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'($urandom));

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/o_serializer.md
O_SERIALIZER -- requirements
Module: o_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: serialization factor in bits per word; legal 3..10.
REQ-002 SHALL have parameter BIT_ORDER, default "LSB_FIRST": transmit order; legal "LSB_FIRST" or "MSB_FIRST".
REQ-003 SHALL have parameter IDLE_VALUE, default 1'b0: level driven on Q when no word is in flight; legal 0 or 1.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port D, input, WIDTH bits: parallel word to serialize.
REQ-007 SHALL have port D_VALID, input, 1 bit: D is valid this cycle.
REQ-008 SHALL have port D_READY, output, 1 bit: block can accept D this cycle.
REQ-009 SHALL have port Q, output, 1 bit: registered serial data, intended to drive the data input of an output buffer.
REQ-010 SHALL have port OE, output, 1 bit: high while Q carries word bits; usable as a tristate-buffer enable.
REQ-011 SHALL have port WORD_START, output, 1 bit: high in the cycle Q carries the first bit of a word.

Function
REQ-012 SHALL, at time 0, call $fatal(1, ...) with the instance path (%m), the offending value, and the legal list if any parameter is out of range.
REQ-013 SHALL contain a one-word holding register HOLD with flag HOLD_V, a WIDTH-bit shift register SR, a bit counter CNT (0..WIDTH-1), and a state machine with states IDLE and SHIFT.
REQ-014 SHALL drive D_READY = !HOLD_V && !RST (combinational).
REQ-015 SHALL treat an edge with D_VALID && D_READY as an accept: HOLD <= D, HOLD_V <= 1; D is ignored when D_READY is 0.
REQ-016 SHALL, in IDLE with HOLD_V = 1: load SR <= HOLD, clear HOLD_V, set CNT <= 0, go to SHIFT; the first bit appears on Q after this edge.
REQ-017 SHALL therefore take 2 edges from accept to first bit on Q when the block starts from IDLE.
REQ-018 SHALL, in SHIFT with CNT < WIDTH-1: shift SR by one bit toward the output and increment CNT.
REQ-019 SHALL, in SHIFT with CNT = WIDTH-1 and HOLD_V = 1: load the next word as in REQ-016 and stay in SHIFT, giving gapless back-to-back words.
REQ-020 SHALL, in SHIFT with CNT = WIDTH-1 and HOLD_V = 0: go to IDLE.
REQ-021 SHALL drive Q as a register:
- SR[0] when BIT_ORDER = "LSB_FIRST";
- SR[WIDTH-1] when BIT_ORDER = "MSB_FIRST";
- IDLE_VALUE in IDLE.
REQ-022 SHALL register OE high exactly in the cycles Q carries a word bit.
REQ-023 SHALL register WORD_START high exactly when CNT = 0 in SHIFT.
REQ-024 SHALL let an accept and a HOLD-to-SR transfer never coincide, because D_READY is low whenever HOLD_V is 1.
REQ-025 SHALL sustain 1 word per WIDTH cycles as peak throughput.
REQ-026 SHALL ignore D_VALID changes while D_READY is low; no data loss and no duplication.

Reset
REQ-027 SHALL, on any edge with RST = 1, apply:
- state IDLE, CNT = 0, HOLD_V = 0, SR = 0;
- Q = IDLE_VALUE, OE = 0, WORD_START = 0.
REQ-028 SHALL hold D_READY at 0 while RST = 1, and raise it in the first cycle after RST falls.
REQ-029 SHALL discard any partially shifted word and any held word when RST is asserted mid-operation; Q returns to IDLE_VALUE on the RST edge.

Verification
REQ-030 SHALL cover single word: WIDTH=4, LSB_FIRST, D=4'b1011 accepted at edge 0.
- Q = 1,1,0,1 after edges 1..4.
- OE = 1 and WORD_START = 1 after edge 1 only.
- Q = IDLE_VALUE and OE = 0 after edge 5.
REQ-031 SHALL cover MSB order: WIDTH=4, MSB_FIRST, D=4'b1011.
- Q = 1,0,1,1.
REQ-032 SHALL cover back-to-back words: D_VALID held high with 4'hA then 4'h5.
- 8 consecutive OE-high cycles with no gap; Q = 0,1,0,1,1,0,1,0 (LSB_FIRST).
- WORD_START pulses after edges 1 and 5.
- D_READY low while HOLD_V = 1.
REQ-033 SHALL cover reset mid-word: RST asserted after bit 2 of 4'hF with IDLE_VALUE = 1.
- Q = 1 and OE = 0 on the next edge; D_READY = 0 during RST.
- A new word 4'h0 sent after RST falls serializes cleanly as 0,0,0,0.
REQ-034 SHALL cover backpressure: D_VALID held with HOLD full.
- The second word is not accepted until the first is loaded into SR; all words emerge in order, none dropped or repeated.
REQ-035 SHALL cover parameter checks: WIDTH=2, WIDTH=11, BIT_ORDER="X", IDLE_VALUE=2.
- Each case ends simulation with $fatal at time 0 and a message naming the parameter.
